// File: rtl/byte_serializer.sv
// Byte FIFO feeding a one-bit-per-clock serializer with optional inter-byte gap.
// Define SERIALIZER_LSB_FIRST_EN to shift bit 0 out first; MSB first otherwise.
module byte_serializer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 0
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          data,
  output logic                          en,
  output logic                          byte_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic                data_q, data_d, en_q, en_d;
  logic                wr_s, pop_s, last_bit_s, not_empty_s;
  logic [DATA_W-1:0]   head_s, shifted_s;

  assign s_ready     = (count_q != CW'(FIFO_DEPTH));
  assign wr_s        = s_valid && s_ready;
  assign not_empty_s = (count_q != '0);
  assign head_s      = mem_q[rd_ptr_q];
  assign last_bit_s  = (bit_cnt_q == BIT_LAST);
  assign fifo_count  = count_q;
  assign data        = data_q;
  assign en          = en_q;

`ifdef SERIALIZER_LSB_FIRST_EN
  assign shifted_s = {1'b0, shreg_q[DATA_W-1:1]};
`else
  assign shifted_s = {shreg_q[DATA_W-2:0], 1'b0};
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= 4'd0;
      data_q    <= 1'b0;
      en_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      en_q      <= en_d;
      mem_q     <= mem_d;
    end
  end

  // Next state, shift register and pop decision
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pop_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (not_empty_s) begin
          pop_s     = 1'b1;
          shreg_d   = head_s;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (!last_bit_s) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shreg_d   = shifted_s;
        end else if (GAP > 0) begin
          gap_cnt_d = 4'd0;
          state_d   = S_GAP;
        end else if (not_empty_s) begin
          pop_s     = 1'b1;
          shreg_d   = head_s;
          bit_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end else if (not_empty_s) begin
          pop_s     = 1'b1;
          shreg_d   = head_s;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, occupancy and storage; a refused write never sees the pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_s) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Registered serial outputs track the bit that will sit at the shift head
  always_comb begin
    en_d      = (state_d == S_SHIFT);
    byte_done = (state_q == S_SHIFT) && last_bit_s;
    if (en_d) begin
`ifdef SERIALIZER_LSB_FIRST_EN
      data_d = shreg_d[0];
`else
      data_d = shreg_d[DATA_W-1];
`endif
    end else begin
      data_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench: default instance (GAP=0) plus a GAP=3 instance sharing clock/reset.
module tb_byte_serializer;

  logic       clk  = 1'b0;
  logic       arst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, data, en, byte_done;
  logic [2:0] fifo_count;

  logic [7:0] g_s_data = 8'h00;
  logic       g_s_valid = 1'b0;
  logic       g_s_ready, g_data, g_en, g_byte_done;
  logic [2:0] g_fifo_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  byte_serializer dut (
    .clk(clk), .arst(arst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .data(data), .en(en), .byte_done(byte_done), .fifo_count(fifo_count)
  );

  byte_serializer #(.GAP(3)) dut_gap (
    .clk(clk), .arst(arst), .s_data(g_s_data), .s_valid(g_s_valid), .s_ready(g_s_ready),
    .data(g_data), .en(g_en), .byte_done(g_byte_done), .fifo_count(g_fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
    return b[i];
`else
    return b[7-i];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bb [3];
  logic [7:0] fb [6];
  logic [7:0] rxb [6];
  logic [7:0] rx;
  logic [7:0] gb [2];
  int idx, nbits, nbytes, en_cycles, first_en, last_en, done_cnt;
  logic hs;

  initial begin
    bb = '{8'h01, 8'hFF, 8'h80};
    fb = '{8'h3C, 8'h96, 8'hE1, 8'h0F, 8'h55, 8'hAA};
    gb = '{8'hC3, 8'h5A};

    // Reset state
    #2;
    chk("rst_en", en, 1'b0);
    chk("rst_data", data, 1'b0);
    chk("rst_done", byte_done, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ready", s_ready, 1'b1);
    step();
    step();
    arst = 1'b0;
    step();
    chk("idle_en", en, 1'b0);

    // Single byte A5
    s_data = 8'hA5; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("single_count_after_wr", fifo_count, 3'd1);
    chk("single_en_before", en, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("single_en_%0d", i), en, 1'b1);
      chk($sformatf("single_bit_%0d", i), data, exp_bit(8'hA5, i));
      chk($sformatf("single_done_%0d", i), byte_done, (i == 7) ? 1'b1 : 1'b0);
      if (i == 0) chk("single_count_after_pop", fifo_count, 3'd0);
    end
    step();
    chk("single_idle_en", en, 1'b0);
    chk("single_idle_data", data, 1'b0);

    // Back-to-back with GAP=0
    s_data = bb[0]; s_valid = 1'b1;
    step();
    for (int i = 0; i < 24; i++) begin
      if (i < 2) s_data = bb[i+1];
      else s_valid = 1'b0;
      step();
      chk($sformatf("b2b_en_%0d", i), en, 1'b1);
      chk($sformatf("b2b_bit_%0d", i), data, exp_bit(bb[i/8], i % 8));
      chk($sformatf("b2b_done_%0d", i), byte_done, ((i % 8) == 7) ? 1'b1 : 1'b0);
    end
    step();
    chk("b2b_idle_en", en, 1'b0);

    // Full FIFO: hold valid across six bytes
    idx = 0; nbits = 0; nbytes = 0; en_cycles = 0; done_cnt = 0;
    first_en = -1; last_en = -1; rx = 8'h00;
    s_valid = 1'b1; s_data = fb[0];
    for (int cyc = 1; cyc <= 60; cyc++) begin
      hs = s_valid && s_ready;
      step();
      if (hs) idx++;
      s_valid = (idx < 6);
      if (idx < 6) s_data = fb[idx];
      if (cyc == 5) begin
        chk("full_count_c5", fifo_count, 3'd4);
        chk("full_ready_c5", s_ready, 1'b0);
      end
      if (cyc == 9) chk("full_ready_c9", s_ready, 1'b0);
      if (cyc == 10) begin
        chk("full_count_c10", fifo_count, 3'd3);
        chk("full_ready_c10", s_ready, 1'b1);
      end
      if (cyc == 11) chk("full_count_c11", fifo_count, 3'd4);
      if (byte_done) done_cnt++;
      if (en) begin
        en_cycles++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
`ifdef SERIALIZER_LSB_FIRST_EN
        rx = {data, rx[7:1]};
`else
        rx = {rx[6:0], data};
`endif
        nbits++;
        if (nbits == 8) begin
          if (nbytes < 6) rxb[nbytes] = rx;
          nbytes++;
          nbits = 0;
        end
      end
    end
    chk("full_accepted", idx, 6);
    chk("full_first_en", first_en, 2);
    chk("full_en_cycles", en_cycles, 48);
    chk("full_contiguous", last_en - first_en + 1, 48);
    chk("full_done_cnt", done_cnt, 6);
    chk("full_nbytes", nbytes, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("full_byte_%0d", i), rxb[i], fb[i]);
    chk("full_empty", fifo_count, 3'd0);

    // GAP=3 instance: two queued bytes
    g_s_data = gb[0]; g_s_valid = 1'b1;
    step();
    g_s_data = gb[1];
    for (int i = 0; i < 20; i++) begin
      if (i == 1) g_s_valid = 1'b0;
      step();
      if (i == 0) chk("gap_count_wr_pop", g_fifo_count, 3'd1);
      if (i < 8) begin
        chk($sformatf("gap_en_%0d", i), g_en, 1'b1);
        chk($sformatf("gap_bit_%0d", i), g_data, exp_bit(gb[0], i));
      end else if (i < 11) begin
        chk($sformatf("gap_en_%0d", i), g_en, 1'b0);
        chk($sformatf("gap_data_%0d", i), g_data, 1'b0);
      end else if (i < 19) begin
        chk($sformatf("gap_en_%0d", i), g_en, 1'b1);
        chk($sformatf("gap_bit_%0d", i), g_data, exp_bit(gb[1], i - 11));
      end else begin
        chk("gap_idle_en", g_en, 1'b0);
      end
      chk($sformatf("gap_done_%0d", i), g_byte_done, (i == 7 || i == 18) ? 1'b1 : 1'b0);
    end

    // Reset in the middle of a byte
    s_data = 8'hA5; s_valid = 1'b1;
    step();
    s_data = 8'h33;
    step();
    s_valid = 1'b0;
    step();
    step();
    chk("mid_en_before_rst", en, 1'b1);
    chk("mid_count_before_rst", fifo_count, 3'd1);
    arst = 1'b1;
    #1;
    chk("mid_rst_en", en, 1'b0);
    chk("mid_rst_data", data, 1'b0);
    chk("mid_rst_done", byte_done, 1'b0);
    chk("mid_rst_count", fifo_count, 3'd0);
    chk("mid_rst_ready", s_ready, 1'b1);
    step();
    arst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post_rst_en_%0d", i), en, 1'b0);
      chk($sformatf("post_rst_count_%0d", i), fifo_count, 3'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
